// File: rtl/mem_stage_hs.sv
// MIPS MEM pipeline stage: aligns every load/store form onto a variable-latency
// data-memory handshake, stalls the pipe while memory is busy and flags a bus error on timeout.
module mem_stage_hs #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int TIMEOUT    = 16,
   parameter bit DEBUG      = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr1_IN,
   input  logic [31:0] Instr1_PC_IN,
   input  logic [31:0] ALU_result1_IN,
   input  logic [4:0]  WriteRegister1_IN,
   input  logic [31:0] MemWriteData1_IN,
   input  logic        RegWrite1_IN,
   input  logic [5:0]  ALU_Control1_IN,
   input  logic        MemRead1_IN,
   input  logic        MemWrite1_IN,
   output logic [4:0]  WriteRegister1_OUT,
   output logic        RegWrite1_OUT,
   output logic [31:0] WriteData1_OUT,
   output logic        STALL_OUT,
   output logic        BusError_OUT,
   output logic [31:0] data_address_2DM,
   output logic [31:0] data_write_2DM,
   output logic [1:0]  data_write_size_2DM,
   output logic        MemRead_2DM,
   output logic        MemWrite_2DM,
   output logic        data_req_2DM,
   input  logic [31:0] data_read_fDM,
   input  logic        data_ack_fDM
);

   localparam logic [5:0] OP_LB  = 6'b100001;
   localparam logic [5:0] OP_LH  = 6'b101011;
   localparam logic [5:0] OP_LBU = 6'b101010;
   localparam logic [5:0] OP_LHU = 6'b101100;
   localparam logic [5:0] OP_LWL = 6'b101101;
   localparam logic [5:0] OP_LWR = 6'b101110;
   localparam logic [5:0] OP_SB  = 6'b101111;
   localparam logic [5:0] OP_SH  = 6'b110000;
   localparam logic [5:0] OP_SWL = 6'b110010;
   localparam logic [5:0] OP_SWR = 6'b110011;

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_op;
   logic             timeout_now;
   logic             stall;

   // Instruction word and PC only feed an external trace; they carry no datapath meaning here.
   logic unused_dbg;
   assign unused_dbg = ^{Instr1_IN, Instr1_PC_IN, DEBUG};

   // Byte lane in big-endian numbering; little-endian mirrors the lane (3-k == ~k).
   logic [1:0]  k;
   logic [4:0]  sh_k, sh_rk;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign mem_op   = MemRead1_IN | MemWrite1_IN;
   assign k        = BIG_ENDIAN ? ALU_result1_IN[1:0] : ~ALU_result1_IN[1:0];
   assign sh_k     = {k, 3'b000};
   assign sh_rk    = {~k, 3'b000};
   assign byte_sel = 8'(data_read_fDM >> sh_rk);
   assign half_sel = k[1] ? data_read_fDM[15:0] : data_read_fDM[31:16];

   logic [31:0] load_data;

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      load_data = data_read_fDM;
      case (ALU_Control1_IN)
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'h0, byte_sel};
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0, half_sel};
         OP_LWL:  load_data = (data_read_fDM << sh_k)
                             | (MemWriteData1_IN & ((32'h1 << sh_k) - 32'h1));
         OP_LWR:  load_data = (data_read_fDM >> sh_rk)
                             | (MemWriteData1_IN & ~(32'hFFFF_FFFF >> sh_rk));
         default: load_data = data_read_fDM;
      endcase
   end

   logic [31:0] st_data, st_addr, word_addr;
   logic [1:0]  st_size;

   assign word_addr = {ALU_result1_IN[31:2], 2'b00};

   always_comb begin
      st_data = MemWriteData1_IN;
      st_size = 2'd0;
      st_addr = word_addr;
      case (ALU_Control1_IN)
         OP_SB: begin
            st_data = {24'h0, MemWriteData1_IN[7:0]};
            st_size = 2'd1;
            st_addr = ALU_result1_IN;
         end
         OP_SH: begin
            st_data = {16'h0, MemWriteData1_IN[15:0]};
            st_size = 2'd2;
            st_addr = {ALU_result1_IN[31:1], 1'b0};
         end
         OP_SWL: begin
            st_data = MemWriteData1_IN >> sh_k;
            st_size = 2'(3'd4 - {1'b0, k});
            st_addr = ALU_result1_IN;
         end
         OP_SWR: begin
            st_data = MemWriteData1_IN;
            st_size = k + 2'd1;
            st_addr = word_addr;
         end
         default: ;
      endcase
   end

   assign data_address_2DM    = MemRead1_IN ? word_addr : st_addr;
   assign data_write_2DM      = st_data;
   assign data_write_size_2DM = st_size;

   // Handshake FSM: IDLE covers zero-wait accesses; WAIT counts cycles until ack or timeout.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_now = 1'b0;
      stall       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op && !data_ack_fDM) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(1);
               stall   = 1'b1;
            end
         end
         S_WAIT: begin
            if (!mem_op || data_ack_fDM) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               timeout_now = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               stall = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset takes the request down at once, without waiting for a clock edge.
   assign data_req_2DM = mem_op & RESET;
   assign MemRead_2DM  = MemRead1_IN & data_req_2DM;
   assign MemWrite_2DM = MemWrite1_IN & data_req_2DM;
   assign STALL_OUT    = stall & RESET;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         WriteRegister1_OUT <= '0;
         RegWrite1_OUT      <= 1'b0;
         WriteData1_OUT     <= '0;
         BusError_OUT       <= 1'b0;
      end else begin
         BusError_OUT <= timeout_now;
         if (STALL_OUT) begin
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            WriteData1_OUT     <= '0;
         end else begin
            WriteRegister1_OUT <= WriteRegister1_IN;
            RegWrite1_OUT      <= RegWrite1_IN & ~timeout_now;
            if (timeout_now)
               WriteData1_OUT <= '0;
            else if (MemRead1_IN)
               WriteData1_OUT <= load_data;
            else
               WriteData1_OUT <= ALU_result1_IN;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: table of load/store/ALU vectors with a
// scoreboard queue, plus hand sequences for wait states, timeout, reset abort and little-endian lanes.
module tb_mem_stage_hs;

   localparam int TIMEOUT = 16;
   localparam int NEVER   = 1000;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
   logic [4:0]  WriteRegister1_IN;
   logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
   logic [5:0]  ALU_Control1_IN;
   logic [31:0] data_read_fDM;
   logic        data_ack_fDM;

   logic [4:0]  WriteRegister1_OUT;
   logic        RegWrite1_OUT, STALL_OUT, BusError_OUT;
   logic [31:0] WriteData1_OUT, data_address_2DM, data_write_2DM;
   logic [1:0]  data_write_size_2DM;
   logic        MemRead_2DM, MemWrite_2DM, data_req_2DM;

   logic [4:0]  le_wreg;
   logic        le_regwr, le_stall, le_berr;
   logic [31:0] le_wdata, le_addr, le_wdm;
   logic [1:0]  le_size;
   logic        le_mrd, le_mwr, le_req;

   always #5 CLK = ~CLK;

   mem_stage_hs #(.BIG_ENDIAN(1'b1), .TIMEOUT(TIMEOUT), .DEBUG(1'b0)) u_dut (
      .CLK(CLK), .RESET(RESET), .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
      .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
      .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
      .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
      .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
      .WriteData1_OUT(WriteData1_OUT), .STALL_OUT(STALL_OUT), .BusError_OUT(BusError_OUT),
      .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
      .data_write_size_2DM(data_write_size_2DM), .MemRead_2DM(MemRead_2DM),
      .MemWrite_2DM(MemWrite_2DM), .data_req_2DM(data_req_2DM),
      .data_read_fDM(data_read_fDM), .data_ack_fDM(data_ack_fDM)
   );

   mem_stage_hs #(.BIG_ENDIAN(1'b0), .TIMEOUT(TIMEOUT), .DEBUG(1'b0)) u_dut_le (
      .CLK(CLK), .RESET(RESET), .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
      .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
      .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
      .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
      .WriteRegister1_OUT(le_wreg), .RegWrite1_OUT(le_regwr),
      .WriteData1_OUT(le_wdata), .STALL_OUT(le_stall), .BusError_OUT(le_berr),
      .data_address_2DM(le_addr), .data_write_2DM(le_wdm),
      .data_write_size_2DM(le_size), .MemRead_2DM(le_mrd),
      .MemWrite_2DM(le_mwr), .data_req_2DM(le_req),
      .data_read_fDM(data_read_fDM), .data_ack_fDM(data_ack_fDM)
   );

   typedef struct {
      string       name;
      logic [5:0]  ctrl;
      bit          rd, wr, rw;
      logic [4:0]  wreg;
      logic [31:0] addr, rt, rdata;
      int          ack_at;
      logic [31:0] exp_wd;
      logic [31:0] exp_dm_addr, exp_dm_data;
      logic [1:0]  exp_size;
   } vec_t;

   typedef struct {
      logic [31:0] wdata;
      bit          regwr;
      logic [4:0]  wreg;
      bit          berr;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [5:0] ctrl, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rdata,
                               input int ack_at, input logic [31:0] exp_wd,
                               input logic [31:0] exp_dm_addr, input logic [31:0] exp_dm_data,
                               input logic [1:0] exp_size);
      vec_t v;
      v.name = name; v.ctrl = ctrl; v.rd = rd; v.wr = wr; v.rw = rd | !wr;
      v.wreg = addr[6:2] ^ 5'd7; v.addr = addr; v.rt = rt; v.rdata = rdata; v.ack_at = ack_at;
      v.exp_wd = exp_wd; v.exp_dm_addr = exp_dm_addr; v.exp_dm_data = exp_dm_data;
      v.exp_size = exp_size;
      return v;
   endfunction

   task automatic drive_idle();
      Instr1_IN = 32'h0; Instr1_PC_IN = 32'h0; ALU_result1_IN = 32'h0; MemWriteData1_IN = 32'h0;
      WriteRegister1_IN = 5'd0; RegWrite1_IN = 1'b1; ALU_Control1_IN = 6'b100000;
      MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0; data_ack_fDM = 1'b0; data_read_fDM = 32'h0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      bit   is_mem, done, to;
      int   stalls, exp_stalls;
      is_mem     = v.rd | v.wr;
      to         = is_mem && (v.ack_at > TIMEOUT - 1);
      exp_stalls = !is_mem ? 0 : (to ? TIMEOUT - 1 : v.ack_at);
      e.wdata = to ? 32'h0 : v.exp_wd;
      e.regwr = to ? 1'b0 : v.rw;
      e.wreg  = v.wreg;
      e.berr  = to;
      sb.push_back(e);
      @(negedge CLK);
      Instr1_IN = 32'h8C00_0000 | {26'h0, v.ctrl}; Instr1_PC_IN = 32'h0040_0000;
      ALU_result1_IN = v.addr; MemWriteData1_IN = v.rt; WriteRegister1_IN = v.wreg;
      RegWrite1_IN = v.rw; ALU_Control1_IN = v.ctrl; MemRead1_IN = v.rd; MemWrite1_IN = v.wr;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge CLK);
         data_ack_fDM  = is_mem && (c == v.ack_at);
         data_read_fDM = data_ack_fDM ? v.rdata : 32'hDEAD_BEEF;
         #1;
         if (c == 0) begin
            check({v.name, ".req"}, data_req_2DM, is_mem);
            if (is_mem) check({v.name, ".dm_addr"}, data_address_2DM, v.exp_dm_addr);
            if (v.wr) begin
               check({v.name, ".dm_data"}, data_write_2DM, v.exp_dm_data);
               check({v.name, ".dm_size"}, data_write_size_2DM, v.exp_size);
            end
         end
         if (STALL_OUT) stalls++;
         else done = 1'b1;
         @(posedge CLK); #1;
         if (!done) check({v.name, ".bubble"}, RegWrite1_OUT, 1'b0);
      end
      check({v.name, ".complete"}, done, 1'b1);
      check({v.name, ".stalls"}, stalls, exp_stalls);
      e = sb.pop_front();
      check({v.name, ".wdata"}, WriteData1_OUT, e.wdata);
      check({v.name, ".regwr"}, RegWrite1_OUT, e.regwr);
      if (!e.berr) check({v.name, ".wreg"}, WriteRegister1_OUT, e.wreg);
      check({v.name, ".berr"}, BusError_OUT, e.berr);
      @(negedge CLK);
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back(mk("alu",    6'b100000, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h1234_5678, 0, 0, 0));
      vecs.push_back(mk("lb",     6'b100001, 1, 0, 32'h1001, 32'h0, 32'h11A2_3344, 0, 32'hFFFF_FFA2, 32'h1000, 0, 0));
      vecs.push_back(mk("lbu",    6'b101010, 1, 0, 32'h1001, 32'h0, 32'h11A2_3344, 0, 32'h0000_00A2, 32'h1000, 0, 0));
      vecs.push_back(mk("lh",     6'b101011, 1, 0, 32'h1002, 32'h0, 32'h1234_8765, 1, 32'hFFFF_8765, 32'h1000, 0, 0));
      vecs.push_back(mk("lhu",    6'b101100, 1, 0, 32'h1001, 32'h0, 32'h8765_1234, 0, 32'h0000_8765, 32'h1000, 0, 0));
      vecs.push_back(mk("lw",     6'b111101, 1, 0, 32'h1003, 32'h0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 32'h1000, 0, 0));
      vecs.push_back(mk("lwl",    6'b101101, 1, 0, 32'h1001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h2233_44DD, 32'h1000, 0, 0));
      vecs.push_back(mk("lwr",    6'b101110, 1, 0, 32'h1001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_1122, 32'h1000, 0, 0));
      vecs.push_back(mk("lwl_k0", 6'b101101, 1, 0, 32'h2000, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h1122_3344, 32'h2000, 0, 0));
      vecs.push_back(mk("lwr_k3", 6'b101110, 1, 0, 32'h2003, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h1122_3344, 32'h2000, 0, 0));
      vecs.push_back(mk("sb",     6'b101111, 0, 1, 32'h3002, 32'h1234_56AB, 32'h0, 0, 32'h3002, 32'h3002, 32'h0000_00AB, 2'd1));
      vecs.push_back(mk("sh",     6'b110000, 0, 1, 32'h3003, 32'h1234_ABCD, 32'h0, 1, 32'h3003, 32'h3002, 32'h0000_ABCD, 2'd2));
      vecs.push_back(mk("sw",     6'b110001, 0, 1, 32'h3001, 32'h1234_ABCD, 32'h0, 0, 32'h3001, 32'h3000, 32'h1234_ABCD, 2'd0));
      vecs.push_back(mk("swl",    6'b110010, 0, 1, 32'h1001, 32'h1234_5678, 32'h0, 0, 32'h1001, 32'h1001, 32'h0012_3456, 2'd3));
      vecs.push_back(mk("swr",    6'b110011, 0, 1, 32'h1002, 32'h1234_5678, 32'h0, 0, 32'h1002, 32'h1000, 32'h1234_5678, 2'd3));
      vecs.push_back(mk("swl_k0", 6'b110010, 0, 1, 32'h1000, 32'h1234_5678, 32'h0, 0, 32'h1000, 32'h1000, 32'h1234_5678, 2'd0));
      vecs.push_back(mk("swr_k3", 6'b110011, 0, 1, 32'h1003, 32'h1234_5678, 32'h0, 0, 32'h1003, 32'h1000, 32'h1234_5678, 2'd0));
      vecs.push_back(mk("rd_alu", 6'b000000, 1, 0, 32'h1002, 32'h0, 32'h89AB_CDEF, 0, 32'h89AB_CDEF, 32'h1000, 0, 0));
      vecs.push_back(mk("lw_ack3", 6'b111101, 1, 0, 32'h5004, 32'h0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 32'h5004, 0, 0));

      RESET = 1'b0;
      drive_idle();
      repeat (2) @(negedge CLK);
      check("rst.wdata", WriteData1_OUT, 32'h0);
      check("rst.regwr", RegWrite1_OUT, 1'b0);
      check("rst.wreg", WriteRegister1_OUT, 5'd0);
      check("rst.berr", BusError_OUT, 1'b0);
      RESET = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Timeout: no ack ever; error pulse lasts exactly one cycle.
      run_vec(mk("lw_to", 6'b111101, 1, 0, 32'h4000, 32'h0, 32'h0, NEVER, 32'h0, 32'h4000, 0, 0));
      @(posedge CLK); #1;
      check("to.berr_pulse", BusError_OUT, 1'b0);

      // Little-endian lane mirroring, observed on the second instance.
      run_vec(mk("lb_lane", 6'b100001, 1, 0, 32'h1001, 32'h0, 32'h1122_B344, 0, 32'h0000_0022, 32'h1000, 0, 0));
      check("le.lb", le_wdata, 32'hFFFF_FFB3);

      // Reset in the middle of a WAIT aborts the request asynchronously.
      @(negedge CLK);
      ALU_result1_IN = 32'h6000; WriteRegister1_IN = 5'd9; RegWrite1_IN = 1'b1;
      ALU_Control1_IN = 6'b111101; MemRead1_IN = 1'b1;
      repeat (3) @(negedge CLK);
      check("wait.req_live", data_req_2DM, 1'b1);
      #2 RESET = 1'b0;
      #1;
      check("rstwait.req", data_req_2DM, 1'b0);
      check("rstwait.wdata", WriteData1_OUT, 32'h0);
      check("rstwait.regwr", RegWrite1_OUT, 1'b0);
      check("rstwait.berr", BusError_OUT, 1'b0);
      @(negedge CLK);
      drive_idle();
      RESET = 1'b1;

      run_vec(mk("lw_to2", 6'b111101, 1, 0, 32'h4008, 32'h0, 32'h0, NEVER, 32'h0, 32'h4008, 0, 0));
      run_vec(mk("post_alu", 6'b100000, 0, 0, 32'hFEED_0001, 32'h0, 32'h0, 0, 32'hFEED_0001, 0, 0, 0));

      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
